// File: rtl/sirv_gnrl_rr_arb_stage_if.sv
// rtl/sirv_gnrl_rr_arb_stage_if.sv - upstream request bundle and downstream command channel of the rr arbiter stage
interface sirv_gnrl_rr_arb_stage_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = 2
);
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_ready;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_last;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic [IW-1:0]   o_id;

  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_last, o_id
  );

  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_last, o_id
  );
endinterface

// File: rtl/sirv_gnrl_rr_arb_stage.sv
// rtl/sirv_gnrl_rr_arb_stage.sv - round-robin arbiter with burst lock and one-entry registered output
module sirv_gnrl_rr_arb_stage #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sirv_gnrl_rr_arb_stage_if.slave bus
);
  logic [IW-1:0] r_rr_ptr;
  logic          r_lock_vld;
  logic [IW-1:0] r_lock_id;
  logic          r_o_valid;
  logic [DW-1:0] r_o_data;
  logic          r_o_last;
  logic [IW-1:0] r_o_id;

  logic          w_stg_en;
  logic          w_acc;
  logic          w_last;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_gid;
  logic [IW-1:0] w_nxt_ptr;
  logic [DW-1:0] w_data;

  assign w_stg_en = ~r_o_valid | bus.o_ready;

  // A locked burst owner is granted on its own valid only, so other requesters never affect i_ready.
  always_comb begin : grant_sel
    logic          found;
    logic [IW-1:0] idx;
    w_grant = '0;
    w_gid   = r_lock_id;
    found   = 1'b0;
    idx     = '0;
    if (r_lock_vld) begin
      w_grant[r_lock_id] = bus.i_valid[r_lock_id];
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = IW'((int'(r_rr_ptr) + k) % N);
        if (!found && bus.i_valid[idx]) begin
          w_grant[idx] = 1'b1;
          w_gid        = idx;
          found        = 1'b1;
        end
      end
    end
  end

  always_comb begin : data_sel
    w_data = '0;
    w_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_grant[k]) begin
        w_data = bus.i_data[k*DW +: DW];
        w_last = bus.i_last[k];
      end
    end
  end

  assign w_acc       = (|w_grant) & w_stg_en & reset;
  assign w_nxt_ptr   = (w_gid == IW'(N - 1)) ? '0 : w_gid + IW'(1);
  assign bus.i_ready = w_grant & {N{w_stg_en & reset}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_last   <= 1'b0;
      r_o_id     <= '0;
    end else begin
      if (w_acc) begin
        r_o_valid <= 1'b1;
        r_o_data  <= w_data;
        r_o_last  <= w_last;
        r_o_id    <= w_gid;
        if (w_last) begin
          r_lock_vld <= 1'b0;
          r_rr_ptr   <= w_nxt_ptr;
        end else begin
          r_lock_vld <= 1'b1;
          r_lock_id  <= w_gid;
        end
      end else if (bus.o_ready) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign bus.o_valid = r_o_valid;
  assign bus.o_data  = r_o_data;
  assign bus.o_last  = r_o_last;
  assign bus.o_id    = r_o_id;
endmodule

// File: doc/sirv_gnrl_rr_arb_stage.md
# sirv_gnrl_rr_arb_stage

Round-robin arbiter with burst lock and a registered output stage. It shares one downstream valid/ready command channel among N upstream requesters. Each accepted beat is forwarded through a one-entry output register tagged with the requester index. A multi-beat burst, delimited by a `last` flag, keeps the grant until its final beat is accepted. The block sits between bus masters (IFU/LSU/debug) and a shared fabric port.

## Interface
Parameters:
- `N`, default 4: number of requesters, must be ≥ 2; need not be a power of 2.
- `DW`, default 32: payload width.
- `IW`, default 2: requester-id width; caller sets it to ceil(log2(N)).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `i_valid`  in  N  per-requester beat valid.
- `i_ready`  out  N  per-requester beat accept.
- `i_data`  in  N*DW  payloads; requester k occupies bits [k*DW +: DW].
- `i_last`  in  N  final beat of the burst (1 = single-beat transfer).
- `o_valid`  out  1  output register holds a beat.
- `o_ready`  in  1  downstream accepts.
- `o_data`  out  DW  forwarded payload.
- `o_last`  out  1  forwarded last flag.
- `o_id`  out  IW  index of the source requester.

## Operation
State flops:
- `rr_ptr` [IW]: highest-priority index.
- `lock_vld`: a burst is in progress.
- `lock_id` [IW]: owner of the burst in progress.
- Output register: `o_valid`, `o_data`, `o_last`, `o_id`.

Stage enable:
- `stg_en = ~o_valid | o_ready`.

Grant (combinational, one-hot or zero):
- If `lock_vld`: `grant = i_valid[lock_id]` at position `lock_id`. Other requesters get no grant, even if they are valid.
- Otherwise: scan k = `rr_ptr`, `rr_ptr`+1, … and wrap N-1 → 0. The first k with `i_valid[k]` wins. If no requester is valid, grant = 0.
- `i_ready[k] = grant[k] & stg_en`. `i_ready` must not depend on `i_valid` of any other requester while locked.

Accept of a beat from requester g (`i_valid[g] & i_ready[g]`):
- Output register loads `i_data[g]`, `i_last[g]`, g, and `o_valid` ← 1.
- If `i_last[g]` = 0: `lock_vld` ← 1, `lock_id` ← g.
- If `i_last[g]` = 1: `lock_vld` ← 0, and `rr_ptr` ← g+1, wrapping to 0 when g+1 = N.

Output drain:
- `o_valid & o_ready` with no new accept in the same cycle: `o_valid` ← 0.
- Data, last and id registers keep their old value; they load only on accept.

Other rules:
- `rr_ptr` changes only when a last beat is accepted. Idle cycles and non-last beats leave it unchanged.
- A locked requester that drops `i_valid` mid-burst keeps the lock. The channel stalls with no timeout.

Reset (reset low, asynchronous):
- `o_valid` = 0, `o_data` = 0, `o_last` = 0, `o_id` = 0.
- `rr_ptr` = 0, `lock_vld` = 0, `lock_id` = 0.
- `i_ready` = 0 while reset is asserted.
- Assertion mid-burst discards the lock and any buffered beat immediately; no beat is forwarded afterwards.
- The first cycle after deassertion arbitrates from index 0.

## Timing
- Latency: a beat accepted on edge t appears on `o_*` after edge t (1 cycle).
- Throughput: 1 beat/cycle while `o_ready` = 1. Accept and drain happen in the same cycle.
- Backpressure: with `o_valid` = 1 and `o_ready` = 0, all `i_ready` = 0 and the register holds.
- Fairness: after a requester completes a burst, every other continuously-valid requester is served before it is served again.
- Upstream obligation: a valid requester holds `i_data`/`i_last` stable until accepted. The block does not check this.

## Test plan
- Reset, then requester 2 sends one beat (`i_last` = 1, data 0xA5) with `o_ready` = 1 → `i_ready` = 4'b0100; next cycle `o_valid` = 1, `o_data` = 0xA5, `o_id` = 2, `o_last` = 1; afterwards `rr_ptr` = 3.
- All four requesters valid continuously, single beats, `o_ready` = 1 → `o_id` sequence 0,1,2,3,0,1; one beat per cycle, no bubbles.
- Requester 1 sends a 3-beat burst while requester 0 is valid throughout → ids 1,1,1 are forwarded before 0; `i_ready[0]` = 0 for all three burst beats.
- Hold `o_ready` = 0 for 5 cycles with an entry buffered → `o_data` stable, all `i_ready` = 0; on release, the buffered beat drains and a new beat is accepted in the same cycle.
- N = 3 build, requester 2 completes a single beat → `rr_ptr` wraps to 0; requesters 0 and 2 both valid → grant goes to 0.
- Assert reset during beat 2 of a 4-beat burst from requester 3 → `o_valid` = 0 at once; after release, requester 1 is granted ahead of requester 3 (scan from 0, requester 3 still valid).
